// File: rtl/mem_access.sv
// MEM-stage memory engine: byte-serial little-endian loads and stores over an
// 8-bit synchronous-read RAM port, raising a stall request while a transfer is in flight.

package mem_access_pkg;
  localparam int ALU_OP_W = 8;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_NOP_OP = 8'h00;
  localparam alu_op_t ALU_ADD_OP = 8'h01;
  localparam alu_op_t ALU_LB_OP  = 8'h10;
  localparam alu_op_t ALU_LH_OP  = 8'h11;
  localparam alu_op_t ALU_LW_OP  = 8'h12;
  localparam alu_op_t ALU_LBU_OP = 8'h13;
  localparam alu_op_t ALU_LHU_OP = 8'h14;
  localparam alu_op_t ALU_SB_OP  = 8'h18;
  localparam alu_op_t ALU_SH_OP  = 8'h19;
  localparam alu_op_t ALU_SW_OP  = 8'h1A;

  localparam logic [1:0] STL_RUN    = 2'b00;
  localparam logic [1:0] STL_STALL  = 2'b01;
  localparam logic [1:0] STL_BUBBLE = 2'b10;
endpackage

module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  alu_op_t           aluop_MEM_i,
  input  logic              wreg_MEM_i,
  input  logic [4:0]        waddr_MEM_i,
  input  logic [31:0]       alurslt_MEM_i,
  input  logic [31:0]       SdataBoffset_MEM_i,
  input  logic [1:0]        stl_STALLER_i,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  output logic              stl_req_o,
  output logic              wreg_WB_o,
  output logic [4:0]        waddr_WB_o,
  output logic [31:0]       wdata_WB_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] ld_buf, ld_buf_nxt;

  logic        is_load, is_store, is_signed, is_mem;
  logic [2:0]  nbytes;
  logic        drive, leave;
  logic [1:0]  ld_idx;
  logic [7:0]  st_byte;
  logic [ADDR_W-1:0] byte_addr;
  logic [31:0] ld_ext;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    nbytes    = 3'd0;
    case (aluop_MEM_i)
      ALU_LB_OP:  begin is_load  = 1'b1; is_signed = 1'b1; nbytes = 3'd1; end
      ALU_LH_OP:  begin is_load  = 1'b1; is_signed = 1'b1; nbytes = 3'd2; end
      ALU_LW_OP:  begin is_load  = 1'b1; nbytes = 3'd4; end
      ALU_LBU_OP: begin is_load  = 1'b1; nbytes = 3'd1; end
      ALU_LHU_OP: begin is_load  = 1'b1; nbytes = 3'd2; end
      ALU_SB_OP:  begin is_store = 1'b1; nbytes = 3'd1; end
      ALU_SH_OP:  begin is_store = 1'b1; nbytes = 3'd2; end
      ALU_SW_OP:  begin is_store = 1'b1; nbytes = 3'd4; end
      ALU_NOP_OP, ALU_ADD_OP: ;
      default: ;
    endcase
  end

  assign is_mem    = is_load | is_store;
  assign byte_addr = alurslt_MEM_i[ADDR_W-1:0] + ADDR_W'(cnt);
  assign st_byte   = 8'(SdataBoffset_MEM_i >> {cnt[1:0], 3'b000});
  // Read data lags the address by one cycle, so it belongs to byte cnt-1.
  assign ld_idx    = 2'(cnt - 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ld_buf <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ld_buf <= ld_buf_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    ld_buf_nxt = ld_buf;
    drive      = 1'b0;
    leave      = 1'b0;
    stl_req_o  = 1'b0;
    mem_wr_o   = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          stl_req_o = 1'b1;
          if (mem_gnt_i) begin
            drive     = 1'b1;
            mem_wr_o  = is_store;
            cnt_nxt   = 3'd1;
            state_nxt = (is_store && nbytes == 3'd1) ? DONE : BUSY;
          end
        end
      end
      BUSY: begin
        stl_req_o = 1'b1;
        cnt_nxt   = cnt + 3'd1;
        if (is_load) begin
          drive = (cnt < nbytes);
          ld_buf_nxt[{ld_idx, 3'b000} +: 8] = mem_din_i;
          if (cnt == nbytes) state_nxt = DONE;
        end else if (is_store) begin
          drive    = 1'b1;
          mem_wr_o = 1'b1;
          if (cnt == nbytes - 3'd1) state_nxt = DONE;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      DONE: begin
        case (stl_STALLER_i)
          STL_STALL:           leave = 1'b0;
          STL_RUN, STL_BUBBLE: leave = 1'b1;
          default:             leave = 1'b1;
        endcase
        if (leave) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Port outputs are forced quiet for as long as reset is held.
    if (!rst) begin
      stl_req_o = 1'b0;
      mem_wr_o  = 1'b0;
      drive     = 1'b0;
    end
  end

  assign mem_a_o    = drive ? byte_addr : '0;
  assign mem_dout_o = (drive && is_store) ? st_byte : '0;

  always_comb begin
    ld_ext = ld_buf;
    if (nbytes == 3'd1)
      ld_ext = is_signed ? {{24{ld_buf[7]}}, ld_buf[7:0]} : {24'd0, ld_buf[7:0]};
    else if (nbytes == 3'd2)
      ld_ext = is_signed ? {{16{ld_buf[15]}}, ld_buf[15:0]} : {16'd0, ld_buf[15:0]};
  end

  assign wdata_WB_o = (state == DONE && is_load) ? ld_ext : alurslt_MEM_i;
  assign wreg_WB_o  = wreg_MEM_i;
  assign waddr_WB_o = waddr_MEM_i;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: a byte-array memory model predicts load data,
// store byte streams and stall lengths from the access rules.
`timescale 1ns/1ps
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int AW    = 17;
  localparam int MSIZE = 1 << AW;
  localparam logic [31:0] AMASK = 32'(MSIZE - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  alu_op_t       aluop = ALU_NOP_OP;
  logic          wreg = 1'b0;
  logic [4:0]    waddr = '0;
  logic [31:0]   alurslt = '0;
  logic [31:0]   sdata = '0;
  logic [1:0]    stl = STL_RUN;
  logic          gnt = 1'b0;
  logic [7:0]    mem_din;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_dout;
  logic          mem_wr, stl_req, wreg_wb;
  logic [4:0]    waddr_wb;
  logic [31:0]   wdata_wb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .aluop_MEM_i(aluop), .wreg_MEM_i(wreg), .waddr_MEM_i(waddr),
    .alurslt_MEM_i(alurslt), .SdataBoffset_MEM_i(sdata),
    .stl_STALLER_i(stl), .mem_gnt_i(gnt), .mem_din_i(mem_din),
    .mem_a_o(mem_a), .mem_dout_o(mem_dout), .mem_wr_o(mem_wr),
    .stl_req_o(stl_req), .wreg_WB_o(wreg_wb), .waddr_WB_o(waddr_wb),
    .wdata_WB_o(wdata_wb)
  );

  // RAM seen by the DUT: unwritten bytes return a fixed hash of their address.
  bit [7:0]      ram [MSIZE];
  bit            ram_vld [MSIZE];
  bit [7:0]      model [MSIZE];
  bit            model_vld [MSIZE];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [7:0]    poke_d = '0;

  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd2654435761;
    return t[23:16];
  endfunction

  always @(posedge clk) begin
    if (poke_en) begin
      ram[poke_a] <= poke_d;
      ram_vld[poke_a] <= 1'b1;
    end else if (mem_wr) begin
      ram[mem_a] <= mem_dout;
      ram_vld[mem_a] <= 1'b1;
    end
    mem_din <= ram_vld[mem_a] ? ram[mem_a] : init_byte(mem_a);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mread(input logic [31:0] a);
    logic [AW-1:0] i;
    i = a[AW-1:0];
    return model_vld[i] ? model[i] : init_byte(i);
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [7:0] d);
    model[a[AW-1:0]] = d;
    model_vld[a[AW-1:0]] = 1'b1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    mwrite(a, d);
    poke_a  = a[AW-1:0];
    poke_d  = d;
    poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic op_info(input alu_op_t op, output int n, output bit ld, output bit sg);
    n = 0; ld = 1'b0; sg = 1'b0;
    case (op)
      ALU_LB_OP:  begin n = 1; ld = 1'b1; sg = 1'b1; end
      ALU_LH_OP:  begin n = 2; ld = 1'b1; sg = 1'b1; end
      ALU_LW_OP:  begin n = 4; ld = 1'b1; end
      ALU_LBU_OP: begin n = 1; ld = 1'b1; end
      ALU_LHU_OP: begin n = 2; ld = 1'b1; end
      ALU_SB_OP:  n = 1;
      ALU_SH_OP:  n = 2;
      ALU_SW_OP:  n = 4;
      default:    n = 0;
    endcase
  endtask

  // One memory instruction from presentation to leaving the completion cycle.
  task automatic run_op(input alu_op_t op, input logic [31:0] addr, input logic [31:0] data,
                        input int gnt_delay, input int hold, input bit bubble,
                        output logic [31:0] got);
    int n, cyc, stalls, nwr;
    bit ld, sg, done;
    logic [31:0] exp, bytes_v;
    logic        wr_v;
    logic [4:0]  wa_v;
    op_info(op, n, ld, sg);
    exp = addr;
    if (ld) begin
      bytes_v = 0;
      for (int k = 0; k < n; k++) bytes_v = bytes_v | (32'(mread(addr + 32'(k))) << (8 * k));
      exp = bytes_v;
      if (sg && n == 1 && bytes_v[7])  exp = bytes_v | 32'hFFFF_FF00;
      if (sg && n == 2 && bytes_v[15]) exp = bytes_v | 32'hFFFF_0000;
    end
    wr_v = 1'($urandom);
    wa_v = 5'($urandom);

    @(posedge clk); #1;
    aluop = op; alurslt = addr; sdata = data; wreg = wr_v; waddr = wa_v;
    stl = STL_RUN; gnt = (gnt_delay == 0);
    cyc = 0; stalls = 0; nwr = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!stl_req) done = 1'b1;
      else begin
        stalls++;
        if (!gnt) begin
          check("nogrant_wr", 32'(mem_wr), 0);
          check("nogrant_addr", 32'(mem_a), 0);
        end
        if (mem_wr) begin
          check("wr_addr", 32'(mem_a), (addr + 32'(nwr)) & AMASK);
          check("wr_data", 32'(mem_dout), (data >> (8 * nwr)) & 32'hFF);
          nwr++;
        end
        if (stalls > 40) begin
          check("timeout_done", 32'(stalls), 32'(n + 1));
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
          cyc++;
          if (cyc >= gnt_delay) gnt = 1'b1;
        end
      end
    end
    check("stall_cycles", 32'(stalls), 32'(gnt_delay + (ld ? n + 1 : n)));
    check("write_count", 32'(nwr), ld ? 32'd0 : 32'(n));
    check("done_wr", 32'(mem_wr), 0);
    check("done_addr", 32'(mem_a), 0);
    check("wdata", wdata_wb, exp);
    check("wreg", 32'(wreg_wb), 32'(wr_v));
    check("waddr", 32'(waddr_wb), 32'(wa_v));
    got = wdata_wb;
    if (!ld)
      for (int k = 0; k < n; k++) mwrite(addr + 32'(k), 8'(data >> (8 * k)));
    if (hold > 0) begin
      stl = STL_STALL;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_req", 32'(stl_req), 0);
        check("hold_wr", 32'(mem_wr), 0);
        check("hold_addr", 32'(mem_a), 0);
        check("hold_wdata", wdata_wb, exp);
      end
    end
    stl = bubble ? STL_BUBBLE : STL_RUN;
  endtask

  task automatic run_alu(input logic [31:0] r, input logic w, input logic [4:0] wa);
    @(posedge clk); #1;
    aluop = ALU_ADD_OP; alurslt = r; wreg = w; waddr = wa; stl = STL_RUN;
    gnt = 1'($urandom);
    #1;
    check("alu_wdata", wdata_wb, r);
    check("alu_wreg", 32'(wreg_wb), 32'(w));
    check("alu_waddr", 32'(waddr_wb), 32'(wa));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("alu_req", 32'(stl_req), 0);
      check("alu_wr", 32'(mem_wr), 0);
      check("alu_addr", 32'(mem_a), 0);
    end
  endtask

  localparam alu_op_t OPS [9] = '{ALU_LB_OP, ALU_LH_OP, ALU_LW_OP, ALU_LBU_OP, ALU_LHU_OP,
                                  ALU_SB_OP, ALU_SH_OP, ALU_SW_OP, ALU_ADD_OP};

  initial begin
    logic [31:0] got, a, last_st;
    alu_op_t op;
    int n;
    bit ld, sg;

    // Reset holds every port output low even with a granted load presented.
    aluop = ALU_LW_OP; alurslt = 32'h100; gnt = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(stl_req), 0);
    check("rst_wr", 32'(mem_wr), 0);
    check("rst_addr", 32'(mem_a), 0);
    check("rst_dout", 32'(mem_dout), 0);
    gnt = 1'b0; aluop = ALU_NOP_OP;
    @(negedge clk); rst = 1'b1;

    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    poke(32'h080, 8'h80); poke(32'h200, 8'h01); poke(32'h201, 8'h80);

    run_op(ALU_LW_OP, 32'h100, 32'h0, 0, 0, 1'b0, got);
    check("lw_word", got, 32'h1234_5678);
    run_op(ALU_LB_OP, 32'h080, 32'h0, 0, 0, 1'b0, got);
    check("lb_sext", got, 32'hFFFF_FF80);
    run_op(ALU_LBU_OP, 32'h080, 32'h0, 0, 0, 1'b0, got);
    check("lbu_zext", got, 32'h0000_0080);
    run_op(ALU_LH_OP, 32'h200, 32'h0, 0, 0, 1'b0, got);
    check("lh_sext", got, 32'hFFFF_8001);
    run_op(ALU_SH_OP, 32'h1FFFF, 32'hAABB_CCDD, 0, 0, 1'b0, got);
    run_op(ALU_LHU_OP, 32'h1FFFF, 32'h0, 0, 0, 1'b0, got);
    check("sh_wrap_readback", got, 32'h0000_CCDD);
    run_alu(32'd7, 1'b1, 5'd5);
    run_op(ALU_SW_OP, 32'h10, 32'hCAFE_F00D, 2, 0, 1'b0, got);
    run_op(ALU_LW_OP, 32'h10, 32'h0, 0, 3, 1'b0, got);
    check("sw_readback", got, 32'hCAFE_F00D);

    // Reset after two bytes of a word load aborts it; the held load then restarts.
    @(posedge clk); #1;
    aluop = ALU_LW_OP; alurslt = 32'h100; gnt = 1'b1; stl = STL_RUN;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("abort_busy", 32'(stl_req), 1);
    rst = 1'b0; #1;
    check("abort_req", 32'(stl_req), 0);
    check("abort_wr", 32'(mem_wr), 0);
    check("abort_addr", 32'(mem_a), 0);
    check("abort_dout", 32'(mem_dout), 0);
    gnt = 1'b0;
    @(negedge clk); rst = 1'b1;
    run_op(ALU_LW_OP, 32'h100, 32'h0, 0, 0, 1'b0, got);
    check("restart_word", got, 32'h1234_5678);

    last_st = 32'h10;
    for (int i = 0; i < 60; i++) begin
      op = OPS[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
        0:       a = 32'h1FFFC + 32'($urandom_range(0, 3));
        1:       a = last_st;
        default: a = 32'($urandom_range(0, MSIZE - 1));
      endcase
      if (op == ALU_ADD_OP) run_alu($urandom, 1'($urandom), 5'($urandom));
      else begin
        op_info(op, n, ld, sg);
        if (!ld) last_st = a;
        run_op(op, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), got);
      end
    end

    @(posedge clk); #1;
    aluop = ALU_NOP_OP;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
